// File: rtl/imem_boot_loader_pkg.sv
// Shared constants and loader state encoding for the instruction-memory boot loader.
// DEPTH defaults to the instruction memory length so all fetch users agree on it.
package imem_boot_loader_pkg;

    localparam int LENGTH          = 32;
    localparam int INST_MEM_LENGTH = 256;
    localparam int WORD_W          = 32;

    typedef enum logic [2:0] {
        LDR_RUN    = 3'd0,
        LDR_HDR_LO = 3'd1,
        LDR_HDR_HI = 3'd2,
        LDR_DATA   = 3'd3,
        LDR_WRITE  = 3'd4,
        LDR_ERR    = 3'd5
    } ldr_state_e;

endpackage

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Assembles little-endian byte streams into 32-bit words; first byte lands in bits [7:0].
// Reusable for any byte-fed memory loader.
module byte_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              byte_en_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_done_o
);

    logic [1:0]        b_q;
    logic [WORD_W-1:0] word_q;

    // Right shift: after four bytes the first one has reached the low lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q    <= '0;
            word_q <= '0;
        end else if (clear_i) begin
            b_q <= '0;
        end else if (byte_en_i) begin
            b_q    <= b_q + 2'd1;
            word_q <= {byte_i, word_q[WORD_W-1:8]};
        end
    end

    assign word_o      = word_q;
    assign word_done_o = byte_en_i && (b_q == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// Owns the instruction memory port: CPU fetch passthrough in RUN, otherwise
// stalls the CPU and writes a length-prefixed byte image word by word.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int DEPTH  = INST_MEM_LENGTH,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    input  logic [LENGTH-1:0] cpu_pc_i,
    output logic [LENGTH-1:0] cpu_instr_o,
    output logic              cpu_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    input  logic [WORD_W-1:0] mem_rdata_i,
    output logic              load_done_o,
    output logic              load_err_o
);

    localparam logic [15:0]       DEPTH16  = 16'(DEPTH);
    localparam logic [LENGTH-1:0] PC_LIMIT = LENGTH'(DEPTH);

    ldr_state_e  state_q;
    logic [15:0] n_q, w_q;
    logic        done_q, err_q;
    logic        accept, word_done;
    logic [15:0] n_full;

    assign accept = byte_valid_i & byte_ready_o;
    assign n_full = {byte_data_i, n_q[7:0]};

    byte_word_packer u_pack (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (state_q == LDR_HDR_HI && accept),
        .byte_en_i   (state_q == LDR_DATA && accept),
        .byte_i      (byte_data_i),
        .word_o      (mem_wdata_o),
        .word_done_o (word_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LDR_RUN;
            n_q     <= '0;
            w_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                LDR_RUN:    if (load_start_i) state_q <= LDR_HDR_LO;
                LDR_HDR_LO: if (accept) begin
                    n_q[7:0] <= byte_data_i;
                    state_q  <= LDR_HDR_HI;
                end
                LDR_HDR_HI: if (accept) begin
                    n_q[15:8] <= byte_data_i;
                    if (n_full == 16'd0) begin
                        state_q <= LDR_RUN;
                        done_q  <= 1'b1;
                    end else if (n_full > DEPTH16) begin
                        state_q <= LDR_ERR;
                        err_q   <= 1'b1;
                    end else begin
                        state_q <= LDR_DATA;
                        w_q     <= '0;
                    end
                end
                LDR_DATA:   if (word_done) state_q <= LDR_WRITE;
                LDR_WRITE: begin
                    if (w_q + 16'd1 == n_q) begin
                        state_q <= LDR_RUN;
                        done_q  <= 1'b1;
                    end else begin
                        w_q     <= w_q + 16'd1;
                        state_q <= LDR_DATA;
                    end
                end
                LDR_ERR:    if (load_start_i) begin
                    err_q   <= 1'b0;
                    state_q <= LDR_HDR_LO;
                end
                default:    state_q <= LDR_RUN;
            endcase
        end
    end

    // Out-of-range PCs fetch a NOP even though the low bits still address memory.
    always_comb begin
        cpu_instr_o  = '0;
        mem_addr_o   = w_q[ADDR_W-1:0];
        cpu_stall_o  = 1'b1;
        byte_ready_o = 1'b0;
        mem_we_o     = 1'b0;
        case (state_q)
            LDR_RUN: begin
                mem_addr_o  = cpu_pc_i[ADDR_W-1:0];
                cpu_stall_o = 1'b0;
                if (cpu_pc_i < PC_LIMIT) cpu_instr_o = mem_rdata_i;
            end
            LDR_HDR_LO, LDR_HDR_HI, LDR_DATA: byte_ready_o = 1'b1;
            LDR_WRITE: mem_we_o = 1'b1;
            default: ;
        endcase
    end

    assign load_done_o = done_q;
    assign load_err_o  = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench: stimulus pushes expected writes/done pulses, a negedge monitor pops and checks.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic [31:0] cpu_pc = 32'd0;
    logic [31:0] cpu_instr;
    logic        cpu_stall;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        load_done;
    logic        load_err;

    imem_boot_loader #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .load_start_i(load_start), .byte_valid_i(byte_valid),
        .byte_data_i(byte_data), .byte_ready_o(byte_ready), .cpu_pc_i(cpu_pc),
        .cpu_instr_o(cpu_instr), .cpu_stall_o(cpu_stall), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_we_o(mem_we), .mem_rdata_i(mem_rdata),
        .load_done_o(load_done), .load_err_o(load_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;
    wr_t         exp_q[$];
    int          done_q[$];
    logic [7:0]  img[$];
    logic [31:0] mem[256];
    logic [31:0] ref_mem[256];
    int total = 0, bad = 0, cyc = 0, done_cyc = 0;

    function automatic logic [31:0] init_val(input int i);
        if (i == 3) return 32'h2002_0005;
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Memory fixture: asynchronous read, write on clk when mem_we.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_addr] = mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    total = total + 1; bad = bad + 1;
                    $display("FAIL unexpected_write: addr %h data %h want none", mem_addr, mem_wdata);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", {24'd0, mem_addr}, {24'd0, e.a});
                    chk("wr_data", mem_wdata, e.d);
                    chk("wr_stall", {31'd0, cpu_stall}, 32'd1);
                end
            end
            if (load_done) begin
                done_cyc = cyc;
                if (done_q.size() == 0) begin
                    total = total + 1; bad = bad + 1;
                    $display("FAIL unexpected_done: got 1 want 0");
                end else begin
                    void'(done_q.pop_front());
                    chk("done_stall", {31'd0, cpu_stall}, 32'd0);
                end
            end
        end
    end

    // Reference model: derive writes and completion straight from the image bytes.
    task automatic expect_image();
        int n;
        logic [31:0] w;
        wr_t e;
        n = int'({img[1], img[0]});
        if (n > 256) return;
        for (int i = 0; i < n; i++) begin
            w = {img[2+4*i+3], img[2+4*i+2], img[2+4*i+1], img[2+4*i]};
            e.a = 8'(i); e.d = w;
            exp_q.push_back(e);
            ref_mem[i] = w;
        end
        done_q.push_back(1);
    endtask

    task automatic make_image(input int n);
        img.delete();
        img.push_back(n[7:0]);
        img.push_back(n[15:8]);
        for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        byte_valid = 1'b1; byte_data = b;
        @(negedge clk);
        while (!byte_ready && t < 200) begin @(negedge clk); t++; end
        if (!byte_ready) begin
            total = total + 1; bad = bad + 1;
            $display("FAIL byte_timeout: ready 0 want 1");
            byte_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input int gap);
        for (int i = lo; i < hi; i++) begin
            send_byte(img[i]);
            if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
        end
    endtask

    task automatic start();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic drain(input string nm);
        repeat (3) @(posedge clk); #1;
        chk({nm, "_writes_left"}, exp_q.size(), 0);
        chk({nm, "_done_left"}, done_q.size(), 0);
    endtask

    task automatic fetch_chk(input logic [31:0] pc);
        cpu_pc = pc; #1;
        chk("fetch", cpu_instr, (pc < 256) ? ref_mem[pc[7:0]] : 32'd0);
    endtask

    initial begin
        int t0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_done", {31'd0, load_done}, 32'd0);
        chk("rst_err", {31'd0, load_err}, 32'd0);

        cpu_pc = 32'd3; #1;
        chk("pt_addr", {24'd0, mem_addr}, 32'd3);
        chk("pt_instr", cpu_instr, 32'h2002_0005);
        fetch_chk(32'd300);
        @(posedge clk); #1;

        // Two-word load, back-to-back
        img = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        expect_image();
        start();
        t0 = cyc;
        chk("start_stall", {31'd0, cpu_stall}, 32'd1);
        send_range(0, img.size(), 0);
        drain("two_word");
        chk("two_word_latency", done_cyc - t0, 12);
        fetch_chk(32'd0);
        fetch_chk(32'd1);

        // Same image with 3-cycle gaps
        expect_image();
        start();
        send_range(0, img.size(), 3);
        drain("gapped");

        // Oversize header, then recovery via zero-length load
        img = '{8'h01, 8'h01};
        start();
        send_range(0, 2, 0);
        repeat (2) @(posedge clk); #1;
        chk("err_level", {31'd0, load_err}, 32'd1);
        chk("err_stall", {31'd0, cpu_stall}, 32'd1);
        chk("err_ready", {31'd0, byte_ready}, 32'd0);
        start();
        chk("err_clear", {31'd0, load_err}, 32'd0);
        chk("err_hdr_ready", {31'd0, byte_ready}, 32'd1);
        img = '{8'h00, 8'h00};
        expect_image();
        send_range(0, 2, 0);
        drain("zero_len");

        // load_start during DATA is ignored
        make_image(2);
        expect_image();
        start();
        send_range(0, 4, 0);
        start();
        send_range(4, img.size(), 0);
        drain("ign_start");

        // Random loads
        for (int k = 0; k < 4; k++) begin
            make_image(int'($urandom_range(1, 6)));
            expect_image();
            start();
            send_range(0, img.size(), int'($urandom_range(0, 2)));
            drain("rand_load");
        end

        // Full-depth load (N == DEPTH is legal)
        make_image(256);
        expect_image();
        start();
        send_range(0, img.size(), 0);
        drain("full_depth");
        for (int k = 0; k < 12; k++) fetch_chk(32'($urandom_range(0, 511)));

        // Reset after the first WRITE of an N=3 load
        make_image(3);
        begin
            wr_t e;
            e.a = 8'd0; e.d = {img[5], img[4], img[3], img[2]};
            exp_q.push_back(e);
            ref_mem[0] = e.d;
        end
        start();
        send_range(0, 6, 0);
        @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("mid_rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("mid_rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
        chk("mid_rst_done", {31'd0, load_done}, 32'd0);
        chk("mid_rst_err", {31'd0, load_err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drain("mid_rst");
        fetch_chk(32'd0);
        fetch_chk(32'd1);
        fetch_chk(32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Controller that owns the single port of a writable instruction memory and shares it between CPU fetch and a byte-stream program loader (e.g. a UART receiver). In RUN it passes the CPU word-indexed PC straight to the memory and returns the instruction combinationally. On `load_start` it stalls the CPU, accepts a length-prefixed little-endian image byte by byte, and writes each assembled 32-bit word to consecutive addresses. It then releases the CPU. It sits between the fetch stage and the instruction memory.

## Interface
- `DEPTH`, default 256: instruction memory depth in words.
- `ADDR_W`, default 8: memory address width; requires 2^ADDR_W >= DEPTH.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load_start` in 1: one-cycle request to begin a load.
- `byte_valid` in 1: loader byte strobe.
- `byte_data` in 8: loader byte.
- `byte_ready` out 1: loader byte accepted when `byte_valid & byte_ready`.
- `cpu_pc` in `LENGTH: word index, as used across the codebase.
- `cpu_instr` out `LENGTH: fetched instruction.
- `cpu_stall` out 1: CPU must hold its PC while high.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_we` out 1: memory write enable, sampled on `clk`.
- `mem_rdata` in 32: memory asynchronous read data.
- `load_done` out 1: one-cycle pulse when a load completes.
- `load_err` out 1: level; the image header was invalid.

## Operation
- **States:** RUN, HDR_LO, HDR_HI, DATA, WRITE, ERR.
- **Reset:** state RUN, word count N=0, word counter W=0, byte index B=0, shift register 0.
  - Registered outputs `load_done` and `load_err` reset to 0.
  - Memory contents are untouched.
- **RUN:**
  - `mem_addr = cpu_pc[ADDR_W-1:0]`.
  - `cpu_instr = mem_rdata` when `cpu_pc < DEPTH`, otherwise 0 (NOP).
  - `cpu_stall=0`, `byte_ready=0`, `mem_we=0`.
  - `load_start` moves to HDR_LO.
- **All other states:** `cpu_stall=1`, `cpu_instr=0`.
- **HDR_LO:** `byte_ready=1`; an accepted byte becomes N[7:0]; go to HDR_HI.
- **HDR_HI:** `byte_ready=1`; an accepted byte becomes N[15:8].
  - N==0: go to RUN and pulse `load_done`.
  - N>DEPTH: go to ERR.
  - Otherwise: go to DATA with W=0, B=0.
- **DATA:** `byte_ready=1`; accepted byte k (B=0..3) fills bits [8k+7:8k] of the word.
  - B wraps from 3 to 0.
  - Accepting the byte at B==3 moves to WRITE.
- **WRITE:** one cycle, `byte_ready=0`, `mem_we=1`, `mem_addr=W`, `mem_wdata`=assembled word.
  - W+1==N: go to RUN and pulse `load_done`.
  - Otherwise: W increments and state returns to DATA.
- **ERR:** `load_err=1`, `byte_ready=0`, CPU stays stalled.
  - `load_start` moves to HDR_LO and clears `load_err`.
- **Ignored inputs:**
  - `load_start` in HDR_LO, HDR_HI, DATA or WRITE.
  - `byte_valid` whenever `byte_ready=0`. The source must hold the byte until accepted.
- **Reset mid-load:** forces RUN. Words already written stay written; there is no rollback.
- **Width rules:**
  - N is 16 bits; W and the N>DEPTH compare use 16-bit unsigned arithmetic.
  - `mem_addr` in WRITE is W[ADDR_W-1:0].
  - `cpu_pc` upper bits are ignored for addressing but used in the range check.

## Timing
- **Fetch latency:** 0 cycles in RUN; memory read and `cpu_instr` are combinational from `cpu_pc`.
- **`load_start` → stall:** `load_start` high at edge t gives `cpu_stall=1` from t+ (the next cycle).
- **Byte throughput:** at most one byte per cycle in HDR/DATA. Each word costs at least 4 DATA cycles plus 1 WRITE cycle.
- **Minimum load time:** 2 + 5N cycles from HDR_LO to RUN.
- **Release timing:**
  - `load_done` is high exactly in the first RUN cycle after the final WRITE (or after HDR_HI when N==0).
  - `cpu_stall` is 0 in that same cycle.
- **Write timing:** `mem_we` is high for exactly one cycle per word, never in RUN.
- **Outputs after reset deassertion:** `cpu_stall=0`, `byte_ready=0`, `mem_we=0`, `load_done=0`, `load_err=0`.

## Structure
- **Shared header:** `LENGTH already exists. Add `INST_MEM_LENGTH-derived DEPTH default and the state encodings (`LDR_RUN … `LDR_ERR, 3 bits) to the shared `head.v`.
- **Sub-module:** one natural sub-module, `byte_word_packer`. It holds B, the shift register and the word-complete strobe, and is reusable for a future data-memory loader.
- **Top level:** FSM, N/W counters and the port mux stay in the top.

## Test plan
- **Fetch passthrough:** after reset, `mem_rdata=32'h2002_0005` at `cpu_pc=3` → `mem_addr=3`, `cpu_instr=32'h2002_0005`, `cpu_stall=0`. `cpu_pc=300` → `cpu_instr=0`.
- **Two-word load:** bytes 02 00 | 78 56 34 12 | EF BE AD DE, back-to-back.
  - Writes 32'h1234_5678 to addr 0 and 32'hDEAD_BEEF to addr 1.
  - `load_done` pulses once, 12 cycles after HDR_LO entry.
  - Stall is released in the same cycle.
- **Gapped source:** same image with `byte_valid` low for 3 cycles between every byte → identical writes and no duplicated bytes.
- **Oversize header:** header 01 01 (N=257 > 256) → ERR, `load_err=1`, no `mem_we`, stall held. A later `load_start` clears `load_err` and returns to HDR_LO.
- **Zero-length and ignored inputs:** header 00 00 → RUN with `load_done` pulse and no writes. A `load_start` asserted during DATA is ignored.
- **Reset mid-load:** `rst` after the first WRITE of an N=3 load → immediately RUN. Addr 0 keeps the new word, addrs 1–2 keep their old contents, and all outputs are at reset values.
